// File: rtl/vx_opd_dispatch_pkg.sv
// vx_opd_dispatch_pkg: shared widths, operand beat layout and dispatcher FSM states
package vx_opd_dispatch_pkg;
  localparam int NUM_EX_UNITS = 3;
  localparam int EX_BITS = 2;
  localparam int WIS_BITS = 2;
  localparam int PAY_BITS = 28;
  localparam int OPD_DATAW = WIS_BITS + EX_BITS + PAY_BITS;
  localparam int PERF_CTR_BITS = 16;
  typedef enum logic {IDLE, IN_PKT} state_t;
  typedef struct packed {
    logic [WIS_BITS-1:0] wis;
    logic [EX_BITS-1:0] ex_type;
    logic [PAY_BITS-1:0] payload;
  } opd_t;
endpackage

// File: rtl/vx_opd_dispatch_if.sv
// vx_opd_dispatch_if: valid/ready operand beat stream with packet delimiters
interface vx_opd_dispatch_if;
  import vx_opd_dispatch_pkg::*;
  logic valid;
  logic ready;
  logic sop;
  logic eop;
  opd_t data;
  modport master(output valid, sop, eop, data, input ready);
  modport slave(input valid, sop, eop, data, output ready);
endinterface

// File: rtl/vx_opd_dispatch_fifo.sv
// vx_opd_dispatch_fifo: power-of-two FIFO with wrap-bit pointers and async active-low clear
module vx_opd_dispatch_fifo #(
  parameter int DEPTH = 2,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATAW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/vx_opd_dispatch.sv
// vx_opd_dispatch: routes operand packets to per-execute-unit FIFOs, locking the target for a whole packet
module vx_opd_dispatch
  import vx_opd_dispatch_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    ISSUE_ID = 0,
  parameter int    NUM_EX = NUM_EX_UNITS,
  parameter int    BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_opd_dispatch_if.slave         operands_if,
  vx_opd_dispatch_if.master        dispatch_if [NUM_EX],
  output logic [PERF_CTR_BITS-1:0] perf_stalls,
  output logic                     proto_err
);
  localparam int EXN = 2 ** EX_BITS;
  state_t state, state_n;
  logic [EX_BITS-1:0] lock_ex, target;
  logic [WIS_BITS-1:0] lock_wis;
  logic lock_disc, in_pkt, bad_ex, discard, proto_hit, fire;
  logic [NUM_EX-1:0] push, full, empty;
  logic [EXN-1:0] full_x;
  assign full_x = EXN'(full);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (fire) state_n = in_pkt ? (operands_if.eop ? IDLE : IN_PKT)
                               : ((operands_if.sop && !operands_if.eop) ? IN_PKT : IDLE);
  end
  // Out-of-range targets are always accepted so a discarded packet never stalls the issue stage
  always_comb begin
    in_pkt = state == IN_PKT;
    bad_ex = int'(operands_if.data.ex_type) >= NUM_EX;
    target = in_pkt ? lock_ex : operands_if.data.ex_type;
    discard = in_pkt ? lock_disc : bad_ex;
    proto_hit = in_pkt ? (operands_if.sop || operands_if.data.ex_type != lock_ex || operands_if.data.wis != lock_wis)
                       : (!operands_if.sop || bad_ex);
    operands_if.ready = reset && (discard || !full_x[target]);
    fire = operands_if.valid && operands_if.ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lock_ex <= '0;
      lock_wis <= '0;
      lock_disc <= 1'b0;
      proto_err <= 1'b0;
      perf_stalls <= '0;
    end else begin
      if (fire && !in_pkt) begin
        lock_ex <= operands_if.data.ex_type;
        lock_wis <= operands_if.data.wis;
        lock_disc <= bad_ex;
      end
      if (fire && proto_hit) proto_err <= 1'b1;
      if (operands_if.valid && !operands_if.ready) perf_stalls <= perf_stalls + 1'b1;
    end
  for (genvar i = 0; i < NUM_EX; i++) begin : g_out
    logic [OPD_DATAW+1:0] dout;
    assign push[i] = fire && !discard && target == EX_BITS'(i);
    vx_opd_dispatch_fifo #(.DEPTH(BUF_DEPTH), .DATAW(OPD_DATAW + 2)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push[i]),
      .pop(dispatch_if[i].valid && dispatch_if[i].ready),
      .din({operands_if.sop, operands_if.eop, operands_if.data}),
      .dout(dout),
      .empty(empty[i]),
      .full(full[i])
    );
    assign dispatch_if[i].valid = !empty[i];
    assign {dispatch_if[i].sop, dispatch_if[i].eop, dispatch_if[i].data} = dout;
    assert property (@(posedge clk) disable iff (!reset) !(push[i] && full[i]))
      else $error("%s[%0d]: push into full buffer %0d", INSTANCE_ID, ISSUE_ID, i);
  end
endmodule

// File: tb/tb_vx_opd_dispatch.sv
// tb_vx_opd_dispatch: scenario tasks plus randomized traffic checked against a queue-based reference model
module tb_vx_opd_dispatch;
  import vx_opd_dispatch_pkg::*;
  localparam int NUM = NUM_EX_UNITS;
  localparam int DEPTH = 2;
  typedef logic [OPD_DATAW+1:0] beat_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PERF_CTR_BITS-1:0] perf_stalls;
  logic proto_err;
  logic [NUM-1:0] rdy = '1;
  logic [NUM-1:0] ov;
  beat_t od [NUM];
  vx_opd_dispatch_if opi ();
  vx_opd_dispatch_if dsp [NUM] ();
  always #5 clk = ~clk;
  for (genvar g = 0; g < NUM; g++) begin : g_tap
    assign dsp[g].ready = rdy[g];
    assign ov[g] = dsp[g].valid;
    assign od[g] = {dsp[g].sop, dsp[g].eop, dsp[g].data};
  end
  vx_opd_dispatch #(.INSTANCE_ID("tb"), .ISSUE_ID(0), .NUM_EX(NUM), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .operands_if(opi),
    .dispatch_if(dsp),
    .perf_stalls(perf_stalls),
    .proto_err(proto_err)
  );
  beat_t mq [NUM][$];
  bit m_pkt, m_disc, m_err, last_fire, rnd_rdy;
  logic [EX_BITS-1:0] m_lock_ex;
  logic [WIS_BITS-1:0] m_lock_wis;
  logic [PERF_CTR_BITS-1:0] m_stalls;
  int checks = 0;
  int errors = 0;
  task automatic model_reset();
    for (int k = 0; k < NUM; k++) mq[k].delete();
    m_pkt = 0;
    m_disc = 0;
    m_err = 0;
    m_stalls = '0;
  endtask
  // One clock: check the DUT against the model, then advance the model across the coming edge
  task automatic cycle();
    int tgt;
    bit disc, er;
    logic [EX_BITS-1:0] ex;
    if (rnd_rdy) rdy = NUM'($urandom);
    ex = opi.data.ex_type;
    tgt = m_pkt ? int'(m_lock_ex) : int'(ex);
    disc = m_pkt ? m_disc : (tgt >= NUM);
    er = disc ? 1'b1 : (mq[tgt].size() < DEPTH);
    @(negedge clk);
    checks++;
    if (opi.ready !== er) begin
      errors++;
      $display("FAIL ready: got %b expected %b", opi.ready, er);
    end
    for (int k = 0; k < NUM; k++) begin
      checks++;
      if (ov[k] !== (mq[k].size() != 0)) begin
        errors++;
        $display("FAIL valid[%0d]: got %b expected %b", k, ov[k], mq[k].size() != 0);
      end
      if (mq[k].size() != 0) begin
        checks++;
        if (od[k] !== mq[k][0]) begin
          errors++;
          $display("FAIL data[%0d]: got %h expected %h", k, od[k], mq[k][0]);
        end
      end
    end
    checks++;
    if (perf_stalls !== m_stalls) begin
      errors++;
      $display("FAIL perf_stalls: got %0d expected %0d", perf_stalls, m_stalls);
    end
    checks++;
    if (proto_err !== m_err) begin
      errors++;
      $display("FAIL proto_err: got %b expected %b", proto_err, m_err);
    end
    last_fire = opi.valid && er;
    if (opi.valid && !er) m_stalls++;
    for (int k = 0; k < NUM; k++)
      if (rdy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    if (last_fire) begin
      m_err = m_err | (m_pkt ? (opi.sop || ex != m_lock_ex || opi.data.wis != m_lock_wis)
                             : (!opi.sop || int'(ex) >= NUM));
      if (!disc) mq[tgt].push_back({opi.sop, opi.eop, opi.data});
      if (!m_pkt && opi.sop && !opi.eop) begin
        m_pkt = 1;
        m_lock_ex = ex;
        m_lock_wis = opi.data.wis;
        m_disc = disc;
      end else if (m_pkt && opi.eop) m_pkt = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit sop, input bit eop, input logic [EX_BITS-1:0] ex, input logic [WIS_BITS-1:0] wis);
    opi.valid = 1'b1;
    opi.sop = sop;
    opi.eop = eop;
    opi.data = '{wis: wis, ex_type: ex, payload: PAY_BITS'($urandom)};
  endtask
  task automatic wait_fire();
    last_fire = 0;
    for (int n = 0; n < 64 && !last_fire; n++) cycle();
    checks++;
    if (!last_fire) begin
      errors++;
      $display("FAIL accept_timeout: accepted 0 expected 1");
    end
    opi.valid = 1'b0;
  endtask
  task automatic send(input bit sop, input bit eop, input logic [EX_BITS-1:0] ex, input logic [WIS_BITS-1:0] wis);
    drive(sop, eop, ex, wis);
    wait_fire();
  endtask
  task automatic idle(input int n);
    opi.valid = 1'b0;
    opi.data = opd_t'($urandom);
    repeat (n) cycle();
  endtask
  task automatic test_reset();
    opi.valid = 1'b1;
    opi.sop = 1'b1;
    opi.eop = 1'b1;
    opi.data = '0;
    #1 reset = 1'b0;
    #2;
    checks += 4;
    if (opi.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", opi.ready); end
    if (ov !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ov); end
    if (perf_stalls !== '0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf_stalls); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", proto_err); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (opi.ready !== 1'b0 || ov !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready %b valid %b expected 0 0", opi.ready, ov);
    end
    opi.valid = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(2);
  endtask
  task automatic test_single();
    rdy = '1;
    send(1, 1, 0, 0);
    send(1, 1, 1, 1);
    send(1, 1, 2, 2);
    idle(3);
    checks++;
    if (perf_stalls !== '0) begin errors++; $display("FAIL single_perf: got %0d expected 0", perf_stalls); end
  endtask
  task automatic test_locked();
    send(1, 0, 1, 1);
    send(0, 0, 0, 1);
    send(0, 0, 0, 1);
    send(0, 1, 0, 1);
    idle(4);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL locked_err: got %b expected 1", proto_err); end
  endtask
  task automatic test_backpressure();
    logic [PERF_CTR_BITS-1:0] base;
    rdy = 3'b110;
    base = perf_stalls;
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    repeat (3) cycle();
    checks++;
    if (perf_stalls !== base + 3) begin
      errors++;
      $display("FAIL bp_perf: got %0d expected %0d", perf_stalls, base + 3);
    end
    rdy = '1;
    wait_fire();
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    idle(4);
  endtask
  task automatic test_discard();
    send(1, 0, 3, 0);
    send(0, 0, 3, 0);
    send(0, 1, 3, 0);
    idle(2);
    checks++;
    if (proto_err !== 1'b1 || ov !== '0) begin
      errors++;
      $display("FAIL discard: err %b valid %b expected 1 000", proto_err, ov);
    end
    send(1, 1, 1, 2);
    idle(2);
  endtask
  task automatic test_mid_reset();
    rdy = 3'b101;
    send(1, 0, 1, 0);
    send(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    reset = 1'b0;
    #2;
    checks += 2;
    if (ov !== '0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ov); end
    if (opi.ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", opi.ready); end
    opi.valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rdy = '1;
    send(1, 1, 2, 3);
    idle(2);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", proto_err); end
  endtask
  task automatic test_random();
    int len;
    logic [EX_BITS-1:0] ex;
    logic [WIS_BITS-1:0] wis;
    rnd_rdy = 1;
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(0, 9) < 2) idle(1);
      len = $urandom_range(1, 4);
      ex = ($urandom_range(0, 15) == 0) ? EX_BITS'(3) : EX_BITS'($urandom_range(0, NUM - 1));
      wis = WIS_BITS'($urandom);
      for (int b = 0; b < len; b++)
        send(b == 0, b == len - 1, ($urandom_range(0, 31) == 0) ? EX_BITS'($urandom) : ex, wis);
    end
    rnd_rdy = 0;
    rdy = '1;
    idle(6);
  endtask
  initial begin
    opi.valid = 1'b0;
    opi.sop = 1'b0;
    opi.eop = 1'b0;
    opi.data = '0;
    model_reset();
    test_reset();
    test_single();
    test_locked();
    test_backpressure();
    test_discard();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
